game_speed_ctrl: RTL

//  Round/level sequencer for the game's speed timer. Generates the 100 ms

---
 rtl/game_pkg.sv | 23 ++
 rtl/tick_gen.sv | 35 +++
 rtl/game_speed_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the game speed sequencer: FSM states,
// speed select codes and the saturating score limit.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_RUN,
    ST_LEVEL,
    ST_OVER
  } state_e;

  localparam logic [1:0] SPEED_SLOW = 2'd0;
  localparam logic [1:0] SPEED_MID  = 2'd1;
  localparam logic [1:0] SPEED_FAST = 2'd2;

  localparam logic [7:0] SCORE_MAX = 8'd255;

  function automatic logic [7:0] score_inc(input logic [7:0] s);
    return (s == SCORE_MAX) ? s : s + 8'd1;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle registered tick every TICK_DIV clocks,
// high while the count sits at TICK_DIV-1.
module tick_gen #(
  parameter int unsigned TICK_DIV = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Tick is registered from the next count so it lines up with count==LAST.
  always_comb begin
    cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    tick_d = (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/game_speed_ctrl.sv
// Round/level sequencer for the speed timer: enable gating, speed select,
// score / miss tracking and game-over, plus the 100 ms tick.
module game_speed_ctrl
  import game_pkg::*;
#(
  parameter int unsigned TICK_DIV       = 5_000_000,
  parameter int unsigned HITS_PER_LEVEL = 4,
  parameter int unsigned MAX_MISSES     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       hit,
  input  logic       timeout,
  output logic       enable,
  output logic [1:0] speed,
  output logic       ms100,
  output logic       level_up,
  output logic       game_over,
  output logic [7:0] score
);

  localparam int unsigned HW = $clog2(HITS_PER_LEVEL + 1);
  localparam int unsigned MW = $clog2(MAX_MISSES + 1);
  localparam logic [HW-1:0] HITS_LAST = HW'(HITS_PER_LEVEL - 1);
  localparam logic [MW-1:0] MISS_LAST = MW'(MAX_MISSES - 1);

  state_e        state_q, state_d;
  logic [7:0]    score_q, score_d;
  logic [HW-1:0] hits_q, hits_d;
  logic [MW-1:0] misses_q, misses_d;
  logic [1:0]    speed_q, speed_d;
  logic          enable_q, level_up_q, game_over_q;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (ms100)
  );

  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    hits_d   = hits_q;
    misses_d = misses_q;
    speed_d  = speed_q;
    unique case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_d  = ST_ARM;
          score_d  = '0;
          hits_d   = '0;
          misses_d = '0;
          speed_d  = SPEED_SLOW;
        end
      end
      ST_ARM: state_d = ST_RUN;
      ST_RUN: begin
        // A hit wins over a same-cycle timeout; the timeout is discarded.
        if (hit) begin
          score_d = score_inc(score_q);
          if (hits_q == HITS_LAST) begin
            hits_d = '0;
            if (speed_q < SPEED_FAST) state_d = ST_LEVEL;
          end else begin
            hits_d = hits_q + 1'b1;
          end
        end else if (timeout) begin
          misses_d = misses_q + 1'b1;
          if (misses_q == MISS_LAST) state_d = ST_OVER;
        end
      end
      ST_LEVEL: begin
        speed_d = speed_q + 2'd1;
        state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      score_q     <= '0;
      hits_q      <= '0;
      misses_q    <= '0;
      speed_q     <= SPEED_SLOW;
      enable_q    <= 1'b0;
      level_up_q  <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      hits_q      <= hits_d;
      misses_q    <= misses_d;
      speed_q     <= speed_d;
      enable_q    <= (state_d == ST_RUN);
      level_up_q  <= (state_d == ST_LEVEL);
      game_over_q <= (state_d == ST_OVER);
    end
  end

  assign enable    = enable_q;
  assign speed     = speed_q;
  assign level_up  = level_up_q;
  assign game_over = game_over_q;
  assign score     = score_q;

endmodule
